lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 250 +++++++++++++++++++++++++
 tb/tb_lsu.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : RV32I load/store unit. Takes one load or store request from the
//            core, issues a single word-aligned bus access with byte enables
//            and lane-replicated store data, and returns sign/zero-extended
//            load data. Illegal width codes and bus timeouts end the
//            transaction with fault set on the done pulse.
// Ports    : clk, rst                 clock, synchronous active-high reset
//            start, we, funct3,       core request (sampled only in IDLE)
//            addr, wdata
//            rdata, done, busy,       load result, completion pulse, stall,
//            fault, misaligned        error flags (valid with done)
//            mem_req, mem_we,         bus request side
//            mem_addr, mem_be,
//            mem_wdata
//            mem_gnt, mem_rvalid,     bus response side
//            mem_rdata
// Params   : TIMEOUT  cycles allowed in REQ+WAIT before abort (1..255)
// Macro    : LSU_MISALIGN_TRAP_EN  when defined, misaligned halfword/word
//            accesses complete immediately with misaligned=1 and no bus
//            access; otherwise the low address bits are simply ignored.
// Revision : 1.0  initial release
// ============================================================================
module lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        fault,
    output logic        misaligned,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_req  = 2'd1;
    localparam logic [1:0] c_wait = 2'd2;
    localparam logic [1:0] c_done = 2'd3;

    // Abort fires on the last permitted cycle that has no bus progress.
    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_rdata;
    logic        r_done;
    logic        r_fault;
    logic        r_misaligned;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;

    logic        w_illegal;
    logic        w_misalign;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;

    // Legal width codes: loads 000/001/010/100/101, stores 000/001/010.
    always_comb begin
        w_illegal = 1'b1;
        if (we) begin
            case (funct3)
                3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
                default:                w_illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_illegal = 1'b0;
                default:                                w_illegal = 1'b1;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Only reached for legal codes, so funct3[1:0] alone identifies the size.
    always_comb begin
        case (funct3[1:0])
            2'b01:   w_misalign = addr[0];
            2'b10:   w_misalign = (addr[1:0] != 2'b00);
            default: w_misalign = 1'b0;
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    // Byte enables and replicated store data so every lane holds the operand.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata;
        case (funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = wdata;
            end
        endcase
        if (!we) begin
            w_be = 4'b1111;
        end
    end

    // Lane selection and extension of the returned word for the captured op.
    assign w_byte = mem_rdata[{r_addr_lo, 3'b000} +: 8];
    assign w_half = mem_rdata[{r_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_ext = {24'd0, w_byte};
            3'b101:  w_load_ext = {16'd0, w_half};
            default: w_load_ext = mem_rdata;
        endcase
    end

    assign w_timeout = (r_cnt >= c_tmo_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_idle;
            r_cnt        <= 8'd0;
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr_lo    <= 2'b00;
            r_rdata      <= 32'd0;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
            r_misaligned <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_be     <= 4'b0000;
            r_mem_wdata  <= 32'd0;
        end else begin
            case (r_state)
                c_idle: begin
                    r_done       <= 1'b0;
                    r_fault      <= 1'b0;
                    r_misaligned <= 1'b0;
                    if (start) begin
                        r_we      <= we;
                        r_funct3  <= funct3;
                        r_addr_lo <= addr[1:0];
                        if (w_illegal) begin
                            r_state <= c_done;
                            r_done  <= 1'b1;
                            r_fault <= 1'b1;
                        end else if (w_misalign) begin
                            r_state      <= c_done;
                            r_done       <= 1'b1;
                            r_misaligned <= 1'b1;
                        end else begin
                            r_state     <= c_req;
                            r_cnt       <= 8'd0;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= we;
                            r_mem_be    <= w_be;
                            r_mem_addr  <= {addr[31:2], 2'b00};
                            r_mem_wdata <= w_wdata;
                        end
                    end
                end
                c_req: begin
                    // Grant wins over a timeout landing in the same cycle.
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_cnt     <= r_cnt + 8'd1;
                        if (r_we) begin
                            r_state <= c_done;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_wait;
                        end
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_state   <= c_done;
                        r_done    <= 1'b1;
                        r_fault   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_wait: begin
                    if (mem_rvalid) begin
                        r_rdata <= w_load_ext;
                        r_state <= c_done;
                        r_done  <= 1'b1;
                    end else if (w_timeout) begin
                        r_state <= c_done;
                        r_done  <= 1'b1;
                        r_fault <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state      <= c_idle;
                    r_done       <= 1'b0;
                    r_fault      <= 1'b0;
                    r_misaligned <= 1'b0;
                end
            endcase
        end
    end

    assign rdata      = r_rdata;
    assign done       = r_done;
    assign busy       = (r_state != c_idle);
    assign fault      = r_fault;
    assign misaligned = r_misaligned;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_be     = r_mem_be;
    assign mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Self-checking bench for lsu. Each transaction's outcome (done
//            cycle, fault/misaligned flags, bus fields, load result) is
//            predicted from a cycle timeline of grant/rvalid arrival against
//            the timeout budget, then compared cycle by cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        busy;
    logic        fault;
    logic        misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rdata = 32'd0;

    lsu #(.TIMEOUT(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .we         (we),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .done       (done),
        .busy       (busy),
        .fault      (fault),
        .misaligned (misaligned),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit legal(input bit w, input logic [2:0] f);
        if (w) return (f == 3'd0 || f == 3'd1 || f == 3'd2);
        return (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5);
    endfunction

    function automatic int size_of(input logic [2:0] f);
        int m = int'(f) % 4;
        return (m == 0) ? 1 : (m == 1) ? 2 : 4;
    endfunction

    function automatic bit misal(input logic [2:0] f, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (a % size_of(f)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_be(input logic [2:0] f, input logic [31:0] a);
        int sz = size_of(f);
        if (sz == 1) return 32'd1 << (a % 4);
        if (sz == 2) return 32'd3 << (2 * ((a / 2) % 2));
        return 32'd15;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f, input logic [31:0] d);
        int sz = size_of(f);
        if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v;
        int sz = size_of(f);
        if (sz == 1) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (f == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (f == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // One transaction: grant arrives g cycles into REQ, rvalid v cycles into
    // WAIT. Cycle 0 is the start cycle; the first REQ cycle is cycle 1.
    task automatic run_txn(input bit twe, input logic [2:0] tf3, input logic [31:0] ta,
                           input logic [31:0] twd, input int g, input int v,
                           input bit fixed, input logic [31:0] frd, input bit noise);
        bit          ok_legal, ok_mis, bus, granted, load_ok, in_wait, real_rv;
        bit          e_fault, e_mis;
        int          dc, req_last, c_g, c_rv, ka, kr;
        logic [31:0] e_new, rd;
        ok_legal = legal(twe, tf3);
        ok_mis   = ok_legal && misal(tf3, ta);
        bus      = ok_legal && !ok_mis;
        granted  = bus && (g <= T - 1);
        e_fault  = !ok_legal;
        e_mis    = ok_mis;
        load_ok  = 1'b0;
        c_g      = g + 1;
        c_rv     = g + 2 + v;
        e_new    = 32'd0;
        if (!bus) begin
            dc = 1;
        end else if (!granted) begin
            dc = T + 1;
            e_fault = 1'b1;
        end else if (twe) begin
            dc = g + 2;
        end else begin
            kr = g + 1 + v;
            ka = (g + 1 > T - 1) ? g + 1 : T - 1;
            if (kr <= ka) begin
                dc = kr + 2;
                load_ok = 1'b1;
            end else begin
                dc = ka + 2;
                e_fault = 1'b1;
            end
        end
        req_last = !bus ? 0 : (granted ? g + 1 : T);

        @(negedge clk);
        start = 1'b1; we = twe; funct3 = tf3; addr = ta; wdata = twd;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= dc + 1; c++) begin
            @(negedge clk);
            if (c == dc && load_ok) exp_rdata = e_new;
            chk("done", done, c == dc);
            chk("busy", busy, c <= dc);
            chk("mem_req", mem_req, c <= req_last);
            if (c <= req_last) begin
                chk("mem_addr", mem_addr, ta & 32'hFFFF_FFFC);
                chk("mem_we", mem_we, twe);
                chk("mem_be", mem_be, twe ? exp_be(tf3, ta) : 32'd15);
                if (twe) chk("mem_wdata", mem_wdata, exp_wdata(tf3, twd));
            end
            if (c == dc) begin
                chk("fault", fault, e_fault);
                chk("misaligned", misaligned, e_mis);
            end
            chk("rdata", rdata, exp_rdata);

            // Inputs for cycle c; anything outside REQ/WAIT must be ignored.
            in_wait = granted && !twe && c >= g + 2 && c <= dc - 1;
            real_rv = granted && !twe && c == c_rv && c <= dc;
            rd = $urandom;
            if (fixed && c == c_rv) rd = frd;
            if (real_rv) e_new = load_val(tf3, ta, rd);
            mem_rdata  = rd;
            mem_gnt    = (c == c_g) || (noise && c > req_last && c <= dc && $urandom_range(0, 1) == 1);
            mem_rvalid = real_rv || (noise && !in_wait && c != c_rv && c <= dc && $urandom_range(0, 1) == 1);
            if (c <= dc && noise) begin
                start = $urandom_range(0, 1) == 1; we = $urandom_range(0, 1) == 1;
                funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
            end else begin
                start = 1'b0;
            end
            if (c == dc + 1) begin
                mem_gnt = 1'b0; mem_rvalid = 1'b0; start = 1'b0;
            end
        end
    endtask

    initial begin
        // Reset state, with a request present that must be ignored.
        rst = 1'b1; start = 1'b1; we = 1'b1; funct3 = 3'd2; addr = 32'h104;
        wdata = 32'h5555_AAAA; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_misaligned", misaligned, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_be", mem_be, 4'b0000);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0; start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;

        // Directed cases.
        run_txn(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'd0, 1'b0);   // SW, done at 2
        run_txn(1'b0, 3'b010, 32'h200, 32'd0, 0, 0, 1'b1, 32'hCAFE_F00D, 1'b0);   // LW, done at 3
        run_txn(1'b0, 3'b000, 32'h103, 32'd0, 0, 0, 1'b1, 32'h80FF_0000, 1'b0);   // LB sign
        run_txn(1'b0, 3'b100, 32'h103, 32'd0, 0, 0, 1'b1, 32'h80FF_0000, 1'b0);   // LBU zero
        run_txn(1'b0, 3'b001, 32'h102, 32'd0, 1, 2, 1'b1, 32'h8001_7FFF, 1'b0);   // LH upper
        run_txn(1'b1, 3'b001, 32'h102, 32'h1234_ABCD, 0, 0, 1'b0, 32'd0, 1'b0);   // SH upper lanes
        run_txn(1'b1, 3'b000, 32'h101, 32'h0000_0077, 2, 0, 1'b0, 32'd0, 1'b0);   // SB lane 1
        run_txn(1'b1, 3'b010, 32'h300, 32'h1111_2222, 50, 0, 1'b0, 32'd0, 1'b0);  // grant never: timeout
        run_txn(1'b0, 3'b010, 32'h300, 32'd0, 0, 50, 1'b0, 32'd0, 1'b0);         // rvalid never: timeout
        run_txn(1'b0, 3'b011, 32'h300, 32'd0, 0, 0, 1'b0, 32'd0, 1'b0);          // illegal load
        run_txn(1'b1, 3'b100, 32'h300, 32'd0, 0, 0, 1'b0, 32'd0, 1'b0);          // illegal store
        run_txn(1'b0, 3'b010, 32'h101, 32'd0, 0, 1, 1'b1, 32'hA5A5_5A5A, 1'b0);  // LW misaligned addr
        run_txn(1'b0, 3'b000, 32'h103, 32'd0, 0, 0, 1'b1, 32'h80FF_0000, 1'b0);  // leaves rdata nonzero

        // Reset while waiting for read data: abandoned, no done, rdata cleared.
        @(negedge clk);
        start = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h400; mem_gnt = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        chk("wait_busy", busy, 1'b1);
        chk("wait_mem_req", mem_req, 1'b0);
        mem_gnt = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        exp_rdata = 32'd0;
        chk("rstw_busy", busy, 1'b0);
        chk("rstw_done", done, 1'b0);
        chk("rstw_rdata", rdata, exp_rdata);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_rvalid = 1'b0; mem_gnt = 1'b1;
            chk("rstw_late_done", done, 1'b0);
            chk("rstw_late_busy", busy, 1'b0);
            chk("rstw_late_rdata", rdata, exp_rdata);
        end
        mem_gnt = 1'b0;

        // Randomised transactions with bus jitter and ignored-input noise.
        for (int n = 0; n < 300; n++) begin
            run_txn($urandom_range(0, 1) == 1, 3'($urandom), $urandom, $urandom,
                    $urandom_range(0, T + 1), $urandom_range(0, T + 1),
                    1'b0, 32'd0, $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
